// File: rtl/echo_ctrl_pkg.sv
// echo_ctrl_pkg: shared FSM encoding, default parameters and sample width for echo_ctrl
package echo_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, GAP, ISSUE} state_t;
  localparam int NUM_D_DEF = 4;
  localparam int NUM_H_DEF = 4;
  localparam int GAP_DEF = 2;
  localparam int SAMPLE_W = 16;
endpackage

// File: rtl/echo_ctrl_if.sv
// echo_ctrl_if: sample stream, target load and echo step handshake; pulse_cnt exists only with ECHO_CTRL_STATS_EN
interface echo_ctrl_if #(parameter int IDX_W = 2);
  import echo_ctrl_pkg::*;
  logic sample_valid;
  logic [SAMPLE_W-1:0] sample_in;
  logic tgt_load;
  logic [IDX_W-1:0] tgt_d;
  logic [IDX_W-1:0] tgt_h;
  logic [SAMPLE_W-1:0] echo_sample;
  logic echo_in_ready;
  logic next_D;
  logic next_H;
  logic echo_out_ready;
  logic [IDX_W-1:0] cur_d;
  logic [IDX_W-1:0] cur_h;
  logic busy;
`ifdef ECHO_CTRL_STATS_EN
  logic [15:0] pulse_cnt;
`endif
  modport master (
    output sample_valid, sample_in, tgt_load, tgt_d, tgt_h, echo_out_ready,
    input echo_sample, echo_in_ready, next_D, next_H, cur_d, cur_h, busy
`ifdef ECHO_CTRL_STATS_EN
    , input pulse_cnt
`endif
  );
  modport slave (
    input sample_valid, sample_in, tgt_load, tgt_d, tgt_h, echo_out_ready,
    output echo_sample, echo_in_ready, next_D, next_H, cur_d, cur_h, busy
`ifdef ECHO_CTRL_STATS_EN
    , output pulse_cnt
`endif
  );
endinterface

// File: rtl/echo_step_tracker.sv
// echo_step_tracker: clamped target plus shadow index that steps forward with wrap at N
module echo_step_tracker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic step,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] cur,
  output logic pend
);
  localparam logic [W-1:0] TOP = W'(N - 1);
  logic [W-1:0] target;
  assign pend = cur != target;
  always_ff @(posedge clk)
    if (reset) begin
      cur <= '0;
      target <= '0;
    end else begin
      if (load) target <= tgt > TOP ? TOP : tgt;
      if (step) cur <= cur == TOP ? '0 : cur + 1'b1;
    end
endmodule

// File: rtl/echo_ctrl.sv
// echo_ctrl: steps the echo's delay/decay toward absolute targets in the quiet gap after a sample.
// Optional ECHO_CTRL_STATS_EN adds a saturating pulse_cnt output.
module echo_ctrl
  import echo_ctrl_pkg::*;
#(
  parameter int NUM_D = NUM_D_DEF,
  parameter int NUM_H = NUM_H_DEF,
  parameter int IDX_W = 2,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input logic clk,
  input logic reset,
  echo_ctrl_if.slave bus
);
  state_t state;
  logic [3:0] cnt;
  logic pend_d, pend_h, issue_ok, step_d, step_h;
  // a sample arriving in the ISSUE cycle cancels the pulse, so pulses never overlap echo_in_ready
  assign issue_ok = state == ISSUE && !bus.sample_valid;
  assign step_d = issue_ok && pend_d;
  assign step_h = issue_ok && !pend_d && pend_h;
  echo_step_tracker #(.N(NUM_D), .W(IDX_W)) u_d (
    .clk, .reset, .load(bus.tgt_load), .step(step_d), .tgt(bus.tgt_d), .cur(bus.cur_d), .pend(pend_d)
  );
  echo_step_tracker #(.N(NUM_H), .W(IDX_W)) u_h (
    .clk, .reset, .load(bus.tgt_load), .step(step_h), .tgt(bus.tgt_h), .cur(bus.cur_h), .pend(pend_h)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.next_D <= 1'b0;
      bus.next_H <= 1'b0;
      bus.echo_in_ready <= 1'b0;
      bus.echo_sample <= '0;
      bus.busy <= 1'b0;
    end else begin
      bus.echo_in_ready <= bus.sample_valid;
      if (bus.sample_valid) bus.echo_sample <= bus.sample_in;
      bus.busy <= pend_d | pend_h;
      bus.next_D <= step_d;
      bus.next_H <= step_h;
      case (state)
        IDLE: if (bus.echo_out_ready && (pend_d || pend_h)) begin
          cnt <= 4'(GAP_CYCLES);
          state <= GAP;
        end
        GAP: begin
          cnt <= cnt - 1'b1;
          state <= bus.sample_valid ? IDLE : cnt == 4'd1 ? ISSUE : GAP;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ECHO_CTRL_STATS_EN
  always_ff @(posedge clk)
    if (reset) bus.pulse_cnt <= '0;
    else if ((bus.next_D || bus.next_H) && bus.pulse_cnt != 16'hFFFF) bus.pulse_cnt <= bus.pulse_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_echo_ctrl.sv
// tb_echo_ctrl: directed scenarios plus randomized traffic against a deadline-based reference model
module tb_echo_ctrl;
  localparam int ND = 4;
  localparam int NH = 3;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  echo_ctrl_if #(.IDX_W(3)) bus ();
  echo_ctrl #(.NUM_D(ND), .NUM_H(NH), .IDX_W(3), .GAP_CYCLES(GAP)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int m_cur_d, m_cur_h, m_tgt_d, m_tgt_h, m_issue_at, m_cyc, m_cnt;
  logic exp_nd, exp_nh, exp_ein, exp_busy;
  logic [15:0] exp_smp;

  task automatic model_clear();
    m_cur_d = 0; m_cur_h = 0; m_tgt_d = 0; m_tgt_h = 0; m_issue_at = -1; m_cyc = 0; m_cnt = 0;
    exp_nd = 0; exp_nh = 0; exp_ein = 0; exp_busy = 0; exp_smp = 0;
  endtask

  task automatic do_reset();
    bus.sample_valid = 0; bus.sample_in = 0; bus.tgt_load = 0; bus.tgt_d = 0; bus.tgt_h = 0; bus.echo_out_ready = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
  endtask

  // one clock of stimulus; the model predicts what the DUT shows after this edge
  task automatic cycle(input logic sv, input logic [15:0] sin, input logic eor, input logic ld, input int td, input int th);
    logic pd, ph, nd, nh;
    bus.sample_valid = sv; bus.sample_in = sin; bus.echo_out_ready = eor;
    bus.tgt_load = ld; bus.tgt_d = 3'(td); bus.tgt_h = 3'(th);
    pd = m_cur_d != m_tgt_d;
    ph = m_cur_h != m_tgt_h;
    if ((exp_nd || exp_nh) && m_cnt != 16'hFFFF) m_cnt++;
    nd = 0; nh = 0;
    if (m_issue_at >= 0) begin
      if (sv) m_issue_at = -1;
      else if (m_cyc == m_issue_at) begin
        m_issue_at = -1;
        if (pd) nd = 1; else if (ph) nh = 1;
      end
    end else if (eor && (pd || ph)) m_issue_at = m_cyc + GAP + 1;
    exp_busy = pd || ph;
    exp_ein = sv;
    if (sv) exp_smp = sin;
    if (ld) begin
      m_tgt_d = td > ND - 1 ? ND - 1 : td;
      m_tgt_h = th > NH - 1 ? NH - 1 : th;
    end
    if (nd) m_cur_d = (m_cur_d + 1) % ND;
    if (nh) m_cur_h = (m_cur_h + 1) % NH;
    exp_nd = nd; exp_nh = nh;
    m_cyc++;
    @(posedge clk); #1;
    bus.sample_valid = 0; bus.echo_out_ready = 0; bus.tgt_load = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic gap_event(output int nd, output int nh, output int at, output int both);
    nd = 0; nh = 0; at = -1; both = 0;
    cycle(0, 16'h0, 1, 0, 0, 0);
    for (int i = 1; i < 20; i++) begin
      idle(1);
      if (bus.next_D) nd++;
      if (bus.next_H) nh++;
      if ((bus.next_D || bus.next_H) && at < 0) at = i;
      if (bus.next_D && bus.next_H) both++;
    end
  endtask

  task automatic test_reset();
    logic [21:0] got;
    do_reset();
    got = {bus.echo_sample, bus.echo_in_ready, bus.next_D, bus.next_H, bus.busy, bus.cur_d[0], bus.cur_h[0]};
    n_cmp++;
    if (got !== 22'h0 || bus.cur_d !== 3'd0 || bus.cur_h !== 3'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h cur_d=%0d cur_h=%0d want all 0", got, bus.cur_d, bus.cur_h);
    end
`ifdef ECHO_CTRL_STATS_EN
    n_cmp++;
    if (bus.pulse_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pulse_cnt got=%0d want 0", bus.pulse_cnt); end
`endif
  endtask

  task automatic test_forward();
    do_reset();
    cycle(1, 16'h0001, 0, 0, 0, 0);
    n_cmp++;
    if (bus.echo_in_ready !== 1'b1 || bus.echo_sample !== 16'h0001) begin
      n_bad++; $display("FAIL fwd_first rdy=%b smp=%h want 1/0001", bus.echo_in_ready, bus.echo_sample);
    end
    n_cmp++;
    if ({bus.next_D, bus.next_H, bus.busy} !== 3'b000 || bus.cur_d !== 3'd0 || bus.cur_h !== 3'd0) begin
      n_bad++; $display("FAIL fwd_quiet nd=%b nh=%b busy=%b cur=%0d/%0d want 0", bus.next_D, bus.next_H, bus.busy, bus.cur_d, bus.cur_h);
    end
    cycle(0, 16'hBEEF, 0, 0, 0, 0);
    n_cmp++;
    if (bus.echo_in_ready !== 1'b0 || bus.echo_sample !== 16'h0001) begin
      n_bad++; $display("FAIL fwd_hold rdy=%b smp=%h want 0/0001", bus.echo_in_ready, bus.echo_sample);
    end
  endtask

  task automatic test_step_count();
    int nd, nh, at, both, total;
    do_reset();
    cycle(0, 16'h0, 0, 1, 2, 0);
    idle(1);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL step_busy_rise got=%b want 1", bus.busy); end
    total = 0;
    for (int e = 0; e < 3; e++) begin
      gap_event(nd, nh, at, both);
      total += nd;
      if (e < 2) begin
        n_cmp++;
        if (nd !== 1 || nh !== 0 || at !== GAP + 1) begin
          n_bad++; $display("FAIL step_event%0d nd=%0d nh=%0d at=%0d want 1/0/%0d", e, nd, nh, at, GAP + 1);
        end
      end
    end
    n_cmp++;
    if (total !== 2 || bus.cur_d !== 3'd2 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL step_total pulses=%0d cur_d=%0d busy=%b want 2/2/0", total, bus.cur_d, bus.busy);
    end
  endtask

  task automatic test_wrap();
    int nd, nh, at, both;
    logic [2:0] seq [2];
    do_reset();
    cycle(0, 16'h0, 0, 1, 3, 0);
    repeat (3) gap_event(nd, nh, at, both);
    n_cmp++;
    if (bus.cur_d !== 3'd3) begin n_bad++; $display("FAIL wrap_start cur_d=%0d want 3", bus.cur_d); end
    cycle(0, 16'h0, 0, 1, 1, 0);
    for (int e = 0; e < 2; e++) begin
      gap_event(nd, nh, at, both);
      seq[e] = bus.cur_d;
    end
    n_cmp++;
    if (seq[0] !== 3'd0 || seq[1] !== 3'd1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL wrap_seq got=%0d,%0d busy=%b want 0,1 busy 0", seq[0], seq[1], bus.busy);
    end
  endtask

  task automatic test_priority();
    int nd, nh, at, both;
    do_reset();
    cycle(0, 16'h0, 0, 1, 1, 1);
    gap_event(nd, nh, at, both);
    n_cmp++;
    if (nd !== 1 || nh !== 0 || both !== 0) begin
      n_bad++; $display("FAIL prio_first nd=%0d nh=%0d both=%0d want 1/0/0", nd, nh, both);
    end
    gap_event(nd, nh, at, both);
    n_cmp++;
    if (nd !== 0 || nh !== 1 || both !== 0 || bus.cur_h !== 3'd1) begin
      n_bad++; $display("FAIL prio_second nd=%0d nh=%0d both=%0d cur_h=%0d want 0/1/0/1", nd, nh, both, bus.cur_h);
    end
  endtask

  task automatic test_suppress();
    int nd, nh, at, both, p;
    do_reset();
    cycle(0, 16'h0, 0, 1, 1, 0);
    cycle(0, 16'h0, 1, 0, 0, 0);
    idle(1);
    cycle(1, 16'h1234, 0, 0, 0, 0);
    p = 0;
    repeat (17) begin idle(1); p += int'(bus.next_D) + int'(bus.next_H); end
    n_cmp++;
    if (p !== 0 || bus.cur_d !== 3'd0) begin n_bad++; $display("FAIL supp_gap pulses=%0d cur_d=%0d want 0/0", p, bus.cur_d); end
    cycle(0, 16'h0, 1, 0, 0, 0);
    idle(GAP);
    cycle(1, 16'h5678, 0, 0, 0, 0);
    n_cmp++;
    if (bus.echo_in_ready !== 1'b1 || bus.next_D !== 1'b0) begin
      n_bad++; $display("FAIL supp_issue_edge rdy=%b nd=%b want 1/0", bus.echo_in_ready, bus.next_D);
    end
    p = 0;
    repeat (16) begin idle(1); p += int'(bus.next_D) + int'(bus.next_H); end
    n_cmp++;
    if (p !== 0 || bus.cur_d !== 3'd0) begin n_bad++; $display("FAIL supp_issue pulses=%0d cur_d=%0d want 0/0", p, bus.cur_d); end
    gap_event(nd, nh, at, both);
    n_cmp++;
    if (nd !== 1 || bus.cur_d !== 3'd1) begin n_bad++; $display("FAIL supp_retry nd=%0d cur_d=%0d want 1/1", nd, bus.cur_d); end
  endtask

  task automatic test_clamp_reset();
    int nd, nh, at, both, sd, sh, p;
    do_reset();
    cycle(0, 16'h0, 0, 1, 7, 7);
    sd = 0; sh = 0;
    repeat (6) begin gap_event(nd, nh, at, both); sd += nd; sh += nh; end
    n_cmp++;
    if (sd !== 3 || sh !== 2 || bus.cur_d !== 3'd3 || bus.cur_h !== 3'd2 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL clamp nd=%0d nh=%0d cur=%0d/%0d busy=%b want 3/2 cur 3/2 busy 0", sd, sh, bus.cur_d, bus.cur_h, bus.busy);
    end
`ifdef ECHO_CTRL_STATS_EN
    n_cmp++;
    if (bus.pulse_cnt !== 16'd5) begin n_bad++; $display("FAIL stats_count got=%0d want 5", bus.pulse_cnt); end
`endif
    cycle(0, 16'h0, 0, 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 0, 0);
    idle(1);
    do_reset();
    p = 0;
    repeat (10) begin idle(1); p += int'(bus.next_D) + int'(bus.next_H); end
    n_cmp++;
    if (p !== 0 || bus.cur_d !== 3'd0 || bus.cur_h !== 3'd0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_gap pulses=%0d cur=%0d/%0d busy=%b want 0", p, bus.cur_d, bus.cur_h, bus.busy);
    end
`ifdef ECHO_CTRL_STATS_EN
    n_cmp++;
    if (bus.pulse_cnt !== 16'd0) begin n_bad++; $display("FAIL stats_clear got=%0d want 0", bus.pulse_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [25:0] got, want;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 3, 16'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      got = {bus.echo_sample, bus.echo_in_ready, bus.next_D, bus.next_H, bus.busy, bus.cur_d, bus.cur_h};
      want = {exp_smp, exp_ein, exp_nd, exp_nh, exp_busy, 3'(m_cur_d), 3'(m_cur_h)};
      n_cmp++;
      if (got !== want || ((bus.next_D || bus.next_H) && bus.echo_in_ready)) begin
        n_bad++; $display("FAIL rand_cycle%0d got=%h want=%h", i, got, want);
      end
`ifdef ECHO_CTRL_STATS_EN
      n_cmp++;
      if (bus.pulse_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rand_cnt%0d got=%0d want=%0d", i, bus.pulse_cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_forward();
    test_step_count();
    test_wrap();
    test_priority();
    test_suppress();
    test_clamp_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
